tl_ul_master: RTL and testbench
===============================

// Module: tl_ul_master
// PURPOSE
//  TileLink-UL initiator. Converts single-beat register commands from a local requester into A-channel requests and waits for the D-channel response.
//  Returns read data and error status to the requester, one outstanding transaction at a time.
//  Sits between the CPU-side bus glue and the TL-UL register slave. It is the peer that drives the slave's a_* inputs and consumes its d_* outputs.
// PARAMETERS
//  ADDR_W   4   address width (a_address, cmd_addr)
//  DATA_W   32  data width; mask width = DATA_W/8
//  TIMEOUT  16  max cycles in D_WAIT without d_valid before aborting (>=2)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       reset, asynchronous, active-low
//  cmd_valid  in   1       requester command valid
//  cmd_ready  out  1       master idle, command accepted when cmd_valid&cmd_ready
//  cmd_write  in   1       1=write (Put*), 0=read (Get)
//  cmd_addr   in   ADDR_W  target register address
//  cmd_mask   in   4       byte enables
//  cmd_wdata  in   DATA_W  write data
//  rsp_valid  out  1       response available
//  rsp_ready  in   1       requester takes response
//  rsp_rdata  out  DATA_W  read data (0 for writes/errors)
//  rsp_err    out  1       bad D opcode or timeout
//  rsp_tmo    out  1       timeout occurred (implies rsp_err)
//  a_valid    out  1       A request valid
//  a_ready    in   1       slave accepts A
//  a_opcode   out  4       0 PutFullData, 1 PutPartialData, 4 Get
//  a_mask     out  4       byte mask
//  a_address  out  ADDR_W  address
//  a_data     out  DATA_W  write data (0 for Get)
//  d_valid    in   1       D response valid
//  d_ready    out  1       master accepts D
//  d_opcode   in   4       0 AccessAck, 1 AccessAckData
//  d_data     in   DATA_W  response data
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; timeout counter 0. Reset mid-transaction aborts it silently (no rsp).
//  FSM: IDLE -> A_REQ -> D_WAIT -> RSP -> IDLE. All outputs are registered.
//  IDLE: cmd_ready=1 (rises the first edge after reset release). On cmd_valid: latch cmd. Opcode = write ? (mask==4'hF ? 0 : 1) : 4.
//   Drive a_*, a_valid=1, cmd_ready=0, go A_REQ.
//  A_REQ: a_valid held, a_* stable until a_ready sampled 1. Then a_valid=0, d_ready=1, go D_WAIT.
//   a_opcode/a_address/a_mask/a_data keep their value after handshake, until the next command.
//  D_WAIT: d_ready=1; counter increments each cycle.
//   On d_valid: d_ready=0, latch response, go RSP.
//    rsp_rdata = d_data if Get and d_opcode==1, else 0.
//    rsp_err = (Get & d_opcode!=1) | (Put & d_opcode!=0).
//   Counter reaches TIMEOUT-1 with no d_valid: go RSP with rsp_err=1, rsp_tmo=1, rsp_rdata=0.
//   d_valid on the same edge as the timeout: d_valid wins.
//  RSP: rsp_valid=1, rsp_* stable until rsp_ready. Then rsp_valid=0, counter=0, cmd_ready=1, IDLE.
//  d_valid while d_ready=0: ignored (late or duplicate beats from the slave are dropped).
//  cmd_* changes while busy: ignored. No pipelining; a new A request is issued only after the RSP handshake.
//  Latency, no stalls: cmd accept edge -> a_valid next cycle. Put d_valid arrives one cycle after the A handshake.
//   rsp_valid follows the d_valid capture edge.
// STRUCTURE
//  Package tl_ul_pkg holds:
//   TL_PUT_FULL=4'h0, TL_PUT_PART=4'h1, TL_GET=4'h4, TL_ACK=4'h0, TL_ACK_DATA=4'h1.
//   FSM state encoding (IDLE=0, A_REQ=1, D_WAIT=2, RSP=3).
//  One sub-module: tl_timeout_cnt (clear/enable counter, param TIMEOUT, output expired).
// TESTING
//  Write full: cmd addr=1, mask=F, wdata=DEADBEEF; slave a_ready=1, d_valid/d_opcode=0 one cycle later
//   -> a_opcode=0, a_data=DEADBEEF; rsp_err=0, rsp_rdata=0.
//  Partial write: mask=4'b0011 -> a_opcode=1, a_mask=3.
//  Read: addr=2; slave returns d_opcode=1, d_data=12345678 two cycles after the A handshake
//   -> a_opcode=4, a_data=0, rsp_rdata=12345678, rsp_err=0.
//  A stall: a_ready low 5 cycles -> a_valid and a_* held stable for 5 cycles, handshake on the 6th.
//  Bad opcode / timeout: Get answered with d_opcode=0 -> rsp_err=1.
//   No d_valid for 16 cycles -> rsp_err=1, rsp_tmo=1; a later stray d_valid is ignored.
//  Reset in D_WAIT and rsp backpressure: rst_n low mid-read -> all outputs 0, no rsp; after release cmd_ready=1.
//   Holding rsp_ready=0 keeps rsp_valid and rsp data stable.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TL-UL opcode constants, initiator FSM encoding and opcode selection helper.
package tl_ul_pkg;

  localparam logic [3:0] TL_PUT_FULL = 4'h0;
  localparam logic [3:0] TL_PUT_PART = 4'h1;
  localparam logic [3:0] TL_GET      = 4'h4;
  localparam logic [3:0] TL_ACK      = 4'h0;
  localparam logic [3:0] TL_ACK_DATA = 4'h1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_A_REQ  = 2'd1,
    ST_D_WAIT = 2'd2,
    ST_RSP    = 2'd3
  } tl_state_e;

  // A write with every byte lane enabled is a full put; anything narrower is partial.
  function automatic logic [3:0] a_opcode_for(input logic write, input logic [3:0] mask);
    if (!write) return TL_GET;
    return (mask == 4'hF) ? TL_PUT_FULL : TL_PUT_PART;
  endfunction

endpackage

// File: rtl/tl_timeout_cnt.sv
// Saturating cycle counter that flags when TIMEOUT-1 cycles have been counted.
module tl_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tl_ul_master.sv
// TL-UL initiator: one outstanding single-beat request, registered A/D/requester interfaces.
module tl_ul_master
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_mask,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_tmo,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [3:0]        a_opcode,
  output logic [3:0]        a_mask,
  output logic [ADDR_W-1:0] a_address,
  output logic [DATA_W-1:0] a_data,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [3:0]        d_opcode,
  input  logic [DATA_W-1:0] d_data
);

  tl_state_e         state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              a_valid_q, a_valid_d;
  logic [3:0]        a_opcode_q, a_opcode_d;
  logic [3:0]        a_mask_q, a_mask_d;
  logic [ADDR_W-1:0] a_address_q, a_address_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic              d_ready_q, d_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_tmo_q, rsp_tmo_d;
  logic              cnt_clr, cnt_en, expired;

  tl_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    a_valid_d   = a_valid_q;
    a_opcode_d  = a_opcode_q;
    a_mask_d    = a_mask_q;
    a_address_d = a_address_q;
    a_data_d    = a_data_q;
    d_ready_d   = d_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    cnt_en      = (state_q == ST_D_WAIT);
    cnt_clr     = (state_q != ST_D_WAIT);

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          a_valid_d   = 1'b1;
          a_opcode_d  = a_opcode_for(cmd_write, cmd_mask);
          a_mask_d    = cmd_mask;
          a_address_d = cmd_addr;
          a_data_d    = cmd_write ? cmd_wdata : '0;
          state_d     = ST_A_REQ;
        end
      end
      ST_A_REQ: begin
        if (a_ready) begin
          a_valid_d = 1'b0;
          d_ready_d = 1'b1;
          state_d   = ST_D_WAIT;
        end
      end
      ST_D_WAIT: begin
        // A response beat on the expiry edge still counts as a normal response.
        if (d_valid) begin
          d_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_tmo_d   = 1'b0;
          if (a_opcode_q == TL_GET) begin
            rsp_rdata_d = (d_opcode == TL_ACK_DATA) ? d_data : '0;
            rsp_err_d   = (d_opcode != TL_ACK_DATA);
          end else begin
            rsp_rdata_d = '0;
            rsp_err_d   = (d_opcode != TL_ACK);
          end
          state_d = ST_RSP;
        end else if (expired) begin
          d_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_mask_q    <= '0;
      a_address_q <= '0;
      a_data_q    <= '0;
      d_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      a_valid_q   <= a_valid_d;
      a_opcode_q  <= a_opcode_d;
      a_mask_q    <= a_mask_d;
      a_address_q <= a_address_d;
      a_data_q    <= a_data_d;
      d_ready_q   <= d_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign a_valid   = a_valid_q;
  assign a_opcode  = a_opcode_q;
  assign a_mask    = a_mask_q;
  assign a_address = a_address_q;
  assign a_data    = a_data_q;
  assign d_ready   = d_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tmo   = rsp_tmo_q;

endmodule

// File: tb/tb_tl_ul_master.sv
// Self-checking bench for tl_ul_master: acts as requester and TL-UL slave, compares against rule-level model.
module tb_tl_ul_master;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_mask;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [DATA_W-1:0] rsp_rdata;
  logic              a_valid, a_ready;
  logic [3:0]        a_opcode, a_mask;
  logic [ADDR_W-1:0] a_address;
  logic [DATA_W-1:0] a_data;
  logic              d_valid, d_ready;
  logic [3:0]        d_opcode;
  logic [DATA_W-1:0] d_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tl_ul_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_mask (cmd_mask),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .rsp_tmo  (rsp_tmo),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_opcode (a_opcode),
    .a_mask   (a_mask),
    .a_address(a_address),
    .a_data   (a_data),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_opcode (d_opcode),
    .d_data   (d_data)
  );

  // Step one clock and settle just past the rising edge, where sampling and driving both happen.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] ctrlWord();
    return 64'({cmd_ready, rsp_valid, rsp_err, rsp_tmo, a_valid, d_ready, a_opcode, a_mask, a_address});
  endfunction

  function automatic logic [63:0] dataWord();
    return 64'({rsp_rdata, a_data});
  endfunction

  function automatic logic [63:0] aWord();
    return 64'({a_opcode, a_mask, a_address, a_data});
  endfunction

  // One full transaction. d_delay counts idle cycles before the D beat; d_delay >= TIMEOUT means no beat.
  task automatic applyStimulus(input bit wr, input logic [ADDR_W-1:0] addr, input logic [3:0] mask,
                               input logic [DATA_W-1:0] wdata, input int a_stall, input int d_delay,
                               input logic [3:0] d_opc, input logic [DATA_W-1:0] d_dat, input int rsp_stall);
    logic [3:0]        exp_opc;
    logic [DATA_W-1:0] exp_adata, exp_rdata;
    logic              exp_err, exp_tmo;
    logic [63:0]       exp_a, exp_rsp;
    int                n, nwait;

    exp_opc   = !wr ? 4'h4 : (mask == 4'hF ? 4'h0 : 4'h1);
    exp_adata = wr ? wdata : '0;
    exp_tmo   = (d_delay >= TIMEOUT);
    exp_err   = exp_tmo || (wr ? (d_opc != 4'h0) : (d_opc != 4'h1));
    exp_rdata = (!exp_tmo && !wr && d_opc == 4'h1) ? d_dat : '0;
    exp_a     = 64'({exp_opc, mask, addr, exp_adata});
    exp_rsp   = 64'({exp_rdata, exp_err, exp_tmo});

    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    if (cmd_ready !== 1'b1) return;

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_mask  = mask;
    cmd_wdata = wdata;
    tick();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom);
    cmd_addr  = ADDR_W'($urandom);
    cmd_mask  = 4'($urandom);
    cmd_wdata = $urandom;
    checkOutput("a_valid_issue", 64'({a_valid, cmd_ready}), 64'b10);
    checkOutput("a_fields_issue", aWord(), exp_a);

    for (int i = 0; i < a_stall; i++) begin
      a_ready = 1'b0;
      tick();
      checkOutput("a_valid_stall", 64'(a_valid), 64'd1);
      checkOutput("a_fields_stall", aWord(), exp_a);
    end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    checkOutput("a_handshake", 64'({a_valid, d_ready}), 64'b01);

    nwait = exp_tmo ? TIMEOUT - 1 : d_delay;
    for (int k = 0; k < nwait; k++) begin
      tick();
      checkOutput("d_wait", 64'({rsp_valid, d_ready}), 64'b01);
    end
    if (!exp_tmo) begin
      d_valid  = 1'b1;
      d_opcode = d_opc;
      d_data   = d_dat;
    end
    tick();
    d_valid   = 1'b0;
    d_opcode  = 4'($urandom);
    d_data    = $urandom;
    cmd_valid = 1'b0;
    checkOutput("rsp_valid_capture", 64'({rsp_valid, d_ready}), 64'b10);
    checkOutput("rsp_fields", 64'({rsp_rdata, rsp_err, rsp_tmo}), exp_rsp);

    // Stray beats during backpressure must not disturb the held response.
    for (int j = 0; j < rsp_stall; j++) begin
      rsp_ready = 1'b0;
      d_valid   = 1'b1;
      d_opcode  = 4'h1;
      d_data    = $urandom;
      tick();
      checkOutput("rsp_hold", 64'({rsp_valid, d_ready}), 64'b10);
      checkOutput("rsp_fields_hold", 64'({rsp_rdata, rsp_err, rsp_tmo}), exp_rsp);
    end
    d_valid   = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_done", 64'({rsp_valid, cmd_ready}), 64'b01);
    checkOutput("a_fields_kept", aWord(), exp_a);
  endtask

  initial begin
    logic              r_wr;
    logic [3:0]        r_mask, r_opc;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_ddata;
    int                r_delay;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_mask  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    a_ready   = 1'b0;
    d_valid   = 1'b0;
    d_opcode  = '0;
    d_data    = '0;

    tick();
    tick();
    checkOutput("reset_ctrl", ctrlWord(), 64'd0);
    checkOutput("reset_data", dataWord(), 64'd0);
    rst_n = 1'b1;
    checkOutput("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
    tick();
    checkOutput("cmd_ready_after_edge", 64'(cmd_ready), 64'd1);

    $display("[TB] directed transactions");
    applyStimulus(1'b1, 4'd1, 4'hF, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0, 0);
    applyStimulus(1'b1, 4'd3, 4'b0011, 32'hCAFEF00D, 0, 0, 4'h0, 32'h0, 0);
    applyStimulus(1'b0, 4'd2, 4'hF, 32'hFFFFFFFF, 0, 1, 4'h1, 32'h12345678, 0);
    applyStimulus(1'b1, 4'd7, 4'hC, 32'hA5A5A5A5, 5, 0, 4'h0, 32'h0, 0);
    applyStimulus(1'b0, 4'd4, 4'hF, 32'h0, 0, 1, 4'h0, 32'h55AA55AA, 0);
    applyStimulus(1'b0, 4'd5, 4'hF, 32'h0, 0, TIMEOUT, 4'h1, 32'h11111111, 2);
    applyStimulus(1'b0, 4'd6, 4'hF, 32'h0, 0, TIMEOUT - 1, 4'h1, 32'h87654321, 0);
    applyStimulus(1'b1, 4'd8, 4'hF, 32'h01020304, 0, 0, 4'h1, 32'h0, 0);
    applyStimulus(1'b0, 4'd9, 4'hF, 32'h0, 1, 0, 4'h1, 32'hBEEF0001, 3);

    $display("[TB] reset in D wait");
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'd2;
    cmd_mask  = 4'hF;
    tick();
    cmd_valid = 1'b0;
    a_ready   = 1'b1;
    tick();
    a_ready = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_d_wait", 64'({rsp_valid, d_ready}), 64'b01);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_ctrl", ctrlWord(), 64'd0);
    checkOutput("midreset_data", dataWord(), 64'd0);
    d_valid  = 1'b1;
    d_opcode = 4'h1;
    d_data   = 32'h99999999;
    tick();
    d_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("post_reset_ready_low", 64'({cmd_ready, rsp_valid}), 64'b00);
    tick();
    checkOutput("post_reset_ready", 64'({cmd_ready, rsp_valid}), 64'b10);

    $display("[TB] random transactions");
    for (int t = 0; t < 20; t++) begin
      r_wr    = 1'($urandom);
      r_addr  = ADDR_W'($urandom);
      r_mask  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      r_wdata = $urandom;
      r_ddata = $urandom;
      case ($urandom_range(0, 3))
        0: r_opc = 4'h0;
        1: r_opc = 4'h1;
        2: r_opc = r_wr ? 4'h0 : 4'h1;
        default: r_opc = 4'($urandom);
      endcase
      r_delay = ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 4));
      applyStimulus(r_wr, r_addr, r_mask, r_wdata, int'($urandom_range(0, 3)), r_delay,
                    r_opc, r_ddata, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
